fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch sequencer.
// Issues one instruction-memory request at a time, loads the instruction
// register, then holds the instruction until decode accepts it.
// Supports branch redirects, halt back to idle, and a sticky fetch timeout.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        CLK,
  input  logic        RST_n,
  input  logic        start,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  output logic        IRWr,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] pc_out,
  output logic [31:0] inst_count,
  output logic        fetch_err
);

  // The wait counter only has to reach TIMEOUT, so it is sized to hold that value.
  localparam int unsigned WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Reaching this count with no imem_ready means the current cycle is the last tolerated one.
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [31:0]   pc;
  logic [WW-1:0] wait_cnt;
  logic          wait_expired;

  // Redirect targets are forced to word alignment, so the low two bits are dropped.
  logic          unused_rpc_bits;
  assign unused_rpc_bits = ^redirect_pc[1:0];

  assign imem_addr    = pc;
  assign wait_expired = (wait_cnt == WAIT_LAST);

  // State register; reset drops straight back to IDLE without waiting for a clock edge.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a redirect always wins over memory or decode handshakes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          state_nxt = FETCH;
        end else if (imem_ready) begin
          state_nxt = HOLD;
        end else if (wait_expired) begin
          state_nxt = ERR;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_nxt = FETCH;
        end else if (inst_ready) begin
          state_nxt = halt ? IDLE : FETCH;
        end
      end
      ERR: begin
        state_nxt = ERR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs decoded from the state alone (plus the same-cycle IR write in FETCH).
  always_comb begin
    imem_req   = 1'b0;
    IRWr       = 1'b0;
    inst_valid = 1'b0;
    case (state)
      FETCH: begin
        imem_req = 1'b1;
        IRWr     = imem_ready & ~redirect;
      end
      HOLD: begin
        inst_valid = 1'b1;
      end
      default: begin
        imem_req   = 1'b0;
      end
    endcase
  end

  // Datapath: program counter, delivered-instruction address and count, wait counter, error flag.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      pc         <= RESET_PC;
      pc_out     <= RESET_PC;
      inst_count <= 32'd0;
      wait_cnt   <= '0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (redirect) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            wait_cnt <= '0;
          end else if (imem_ready) begin
            pc_out   <= pc;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_expired) begin
              fetch_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc       <= {redirect_pc[31:2], 2'b00};
            wait_cnt <= '0;
          end else if (inst_ready) begin
            pc         <= pc + 32'd4;
            inst_count <= inst_count + 32'd1;
          end
        end
        default: begin
          pc <= pc;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: self-checking bench for fetch_ctrl.
// Directed table of vectors, hand-written corner sequences, then randomized
// traffic compared against a behavioural model of the fetch rules.
module tb_fetch_ctrl;

  localparam int TIMEOUT = 15;

  logic        CLK = 1'b0;
  logic        RST_n = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        imem_ready = 1'b0;
  logic        inst_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_req;
  logic        IRWr;
  logic        inst_valid;
  logic        fetch_err;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] inst_count;

  int total = 0;
  int bad = 0;
  bit modelOn = 1'b0;

  // Behavioural model: running/holding/dead flags plus architectural values.
  bit          mActive;
  bit          mHolding;
  bit          mDead;
  logic [31:0] mPc;
  logic [31:0] mPcOut;
  logic [31:0] mCnt;
  int          mWait;

  typedef struct {
    logic        start;
    logic        halt;
    logic        ready;
    logic        iready;
    logic        redir;
    logic [31:0] rpc;
    logic        req;
    logic        irwr;
    logic        valid;
    logic [31:0] addr;
    logic [31:0] pcout;
    logic [31:0] cnt;
    logic        err;
  } vec_t;

  vec_t vecs[19];

  fetch_ctrl dut (
    .CLK        (CLK),
    .RST_n      (RST_n),
    .start      (start),
    .halt       (halt),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .IRWr       (IRWr),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .pc_out     (pc_out),
    .inst_count (inst_count),
    .fetch_err  (fetch_err)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 CLK = ~CLK;

  function automatic void modelReset();
    mActive  = 1'b0;
    mHolding = 1'b0;
    mDead    = 1'b0;
    mPc      = 32'h0000_3000;
    mPcOut   = 32'h0000_3000;
    mCnt     = 32'd0;
    mWait    = 0;
  endfunction

  function automatic void modelStep();
    if (mDead) return;
    if (!mActive) begin
      if (start) mActive = 1'b1;
      return;
    end
    if (redirect) begin
      mPc      = {redirect_pc[31:2], 2'b00};
      mWait    = 0;
      mHolding = 1'b0;
      return;
    end
    if (!mHolding) begin
      if (imem_ready) begin
        mPcOut   = mPc;
        mHolding = 1'b1;
        mWait    = 0;
      end else begin
        mWait = mWait + 1;
        if (mWait == TIMEOUT) begin
          mDead   = 1'b1;
          mActive = 1'b0;
        end
      end
    end else if (inst_ready) begin
      mPc      = mPc + 32'd4;
      mCnt     = mCnt + 32'd1;
      mHolding = 1'b0;
      if (halt) mActive = 1'b0;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic req, input logic irwr, input logic valid,
                          input logic [31:0] addr, input logic [31:0] pcout, input logic [31:0] cnt,
                          input logic err);
    checkOutput({tag, ".imem_req"},   {31'd0, imem_req},   {31'd0, req});
    checkOutput({tag, ".IRWr"},       {31'd0, IRWr},       {31'd0, irwr});
    checkOutput({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, valid});
    checkOutput({tag, ".imem_addr"},  imem_addr,  addr);
    checkOutput({tag, ".pc_out"},     pc_out,     pcout);
    checkOutput({tag, ".inst_count"}, inst_count, cnt);
    checkOutput({tag, ".fetch_err"},  {31'd0, fetch_err},  {31'd0, err});
  endtask

  task automatic setInputs(input logic s, input logic h, input logic r, input logic ir,
                           input logic rd, input logic [31:0] rpc);
    start       = s;
    halt        = h;
    imem_ready  = r;
    inst_ready  = ir;
    redirect    = rd;
    redirect_pc = rpc;
  endtask

  task automatic advance();
    @(posedge CLK);
    if (modelOn) modelStep();
    #1;
  endtask

  task automatic doReset();
    setInputs(0, 0, 0, 0, 0, 32'd0);
    RST_n = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RST_n = 1'b1;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    setInputs(v.start, v.halt, v.ready, v.iready, v.redir, v.rpc);
    #3;
    checkAll($sformatf("vec%0d", idx), v.req, v.irwr, v.valid, v.addr, v.pcout, v.cnt, v.err);
    advance();
  endtask

  task automatic addVec(input int i, input logic s, input logic h, input logic r, input logic ir,
                        input logic rd, input logic [31:0] rpc, input logic req, input logic irwr,
                        input logic valid, input logic [31:0] addr, input logic [31:0] pcout,
                        input logic [31:0] cnt);
    vecs[i].start = s;   vecs[i].halt = h;     vecs[i].ready = r;
    vecs[i].iready = ir; vecs[i].redir = rd;   vecs[i].rpc = rpc;
    vecs[i].req = req;   vecs[i].irwr = irwr;  vecs[i].valid = valid;
    vecs[i].addr = addr; vecs[i].pcout = pcout; vecs[i].cnt = cnt;
    vecs[i].err = 1'b0;
  endtask

  initial begin
    int readyPct;

    // Basic fetch, decode backpressure, redirect priority in FETCH and HOLD.
    addVec(0,  0,0,0,0,0, 32'h0,         0,0,0, 32'h3000, 32'h3000, 0);
    addVec(1,  1,0,0,0,0, 32'h0,         0,0,0, 32'h3000, 32'h3000, 0);
    addVec(2,  0,0,0,0,0, 32'h0,         1,0,0, 32'h3000, 32'h3000, 0);
    addVec(3,  0,0,1,0,0, 32'h0,         1,1,0, 32'h3000, 32'h3000, 0);
    addVec(4,  0,0,0,1,0, 32'h0,         0,0,1, 32'h3000, 32'h3000, 0);
    addVec(5,  0,0,0,0,0, 32'h0,         1,0,0, 32'h3004, 32'h3000, 1);
    addVec(6,  0,0,1,0,0, 32'h0,         1,1,0, 32'h3004, 32'h3000, 1);
    addVec(7,  0,0,0,0,0, 32'h0,         0,0,1, 32'h3004, 32'h3004, 1);
    addVec(8,  0,0,0,0,0, 32'h0,         0,0,1, 32'h3004, 32'h3004, 1);
    addVec(9,  0,0,1,0,0, 32'h0,         0,0,1, 32'h3004, 32'h3004, 1);
    addVec(10, 0,0,1,0,0, 32'h0,         0,0,1, 32'h3004, 32'h3004, 1);
    addVec(11, 0,0,0,0,0, 32'h0,         0,0,1, 32'h3004, 32'h3004, 1);
    addVec(12, 0,0,0,1,0, 32'h0,         0,0,1, 32'h3004, 32'h3004, 1);
    addVec(13, 0,0,0,0,0, 32'h0,         1,0,0, 32'h3008, 32'h3004, 2);
    addVec(14, 0,0,1,0,1, 32'h0000_4003, 1,0,0, 32'h3008, 32'h3004, 2);
    addVec(15, 0,0,0,0,0, 32'h0,         1,0,0, 32'h4000, 32'h3004, 2);
    addVec(16, 0,0,1,0,0, 32'h0,         1,1,0, 32'h4000, 32'h3004, 2);
    addVec(17, 0,0,0,1,1, 32'h0000_5009, 0,0,1, 32'h4000, 32'h4000, 2);
    addVec(18, 0,0,0,0,0, 32'h0,         1,0,0, 32'h5008, 32'h4000, 2);

    doReset();
    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

    // Halt with PC wrap: redirect to the top word, deliver it, halt, then restart at 0.
    setInputs(0, 0, 0, 0, 1, 32'hFFFF_FFFE); #3;
    checkAll("wrap.redir", 1, 0, 0, 32'h5008, 32'h4000, 2, 0);
    advance();
    setInputs(0, 0, 1, 0, 0, 32'd0); #3;
    checkAll("wrap.fetch", 1, 1, 0, 32'hFFFF_FFFC, 32'h4000, 2, 0);
    advance();
    setInputs(0, 1, 0, 1, 0, 32'd0); #3;
    checkAll("wrap.hold", 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2, 0);
    advance();
    setInputs(0, 0, 0, 0, 1, 32'h0000_7000); #3;
    checkAll("wrap.idle", 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 3, 0);
    advance();
    setInputs(1, 0, 0, 0, 0, 32'd0); #3;
    checkAll("wrap.idleredir", 0, 0, 0, 32'h0, 32'hFFFF_FFFC, 3, 0);
    advance();
    setInputs(0, 0, 0, 0, 0, 32'd0); #3;
    checkAll("wrap.resume", 1, 0, 0, 32'h0, 32'hFFFF_FFFC, 3, 0);

    // Reset mid-FETCH with data arriving: the IR write must vanish at once.
    imem_ready = 1'b1; #1;
    checkOutput("rstfetch.IRWr_pre", {31'd0, IRWr}, 32'd1);
    RST_n = 1'b0; #1;
    checkAll("rstfetch", 0, 0, 0, 32'h3000, 32'h3000, 0, 0);
    doReset();

    // Asynchronous reset while holding an instruction, between clock edges.
    setInputs(1, 0, 0, 0, 0, 32'd0); advance();
    setInputs(0, 0, 1, 0, 0, 32'd0); advance();
    setInputs(0, 0, 0, 1, 0, 32'd0); advance();
    setInputs(0, 0, 1, 0, 0, 32'd0); advance();
    setInputs(0, 0, 0, 0, 0, 32'd0); #2;
    checkAll("rsthold.pre", 0, 0, 1, 32'h3004, 32'h3004, 1, 0);
    RST_n = 1'b0; #1;
    checkAll("rsthold.async", 0, 0, 0, 32'h3000, 32'h3000, 0, 0);
    doReset();

    // Timeout: fifteen FETCH cycles without data, then ERR ignores everything.
    setInputs(1, 0, 0, 0, 0, 32'd0); advance();
    for (int k = 1; k <= TIMEOUT; k++) begin
      setInputs(0, 0, 0, 0, 0, 32'd0); #3;
      checkOutput($sformatf("tmo.wait%0d.req", k), {31'd0, imem_req}, 32'd1);
      checkOutput($sformatf("tmo.wait%0d.err", k), {31'd0, fetch_err}, 32'd0);
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      setInputs(1, 0, 1, 1, 1, 32'h0000_8000); #3;
      checkAll($sformatf("tmo.err%0d", k), 0, 0, 0, 32'h3000, 32'h3000, 0, 1);
      advance();
    end
    doReset(); #3;
    checkAll("tmo.cleared", 0, 0, 0, 32'h3000, 32'h3000, 0, 0);
    advance();
    setInputs(1, 0, 0, 0, 0, 32'd0); advance();
    setInputs(0, 0, 0, 0, 0, 32'd0); #3;
    checkAll("tmo.restart", 1, 0, 0, 32'h3000, 32'h3000, 0, 0);
    advance();

    // Randomized traffic against the behavioural model, alternating fast and slow memory.
    modelOn = 1'b1;
    doReset();
    modelReset();
    for (int c = 0; c < 3000; c++) begin
      if (c != 0 && (c % 500) == 0) begin
        doReset();
        modelReset();
      end
      readyPct = (((c / 250) % 2) == 0) ? 75 : 12;
      setInputs($urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                $urandom_range(0, 99) < readyPct, $urandom_range(0, 2) != 0,
                $urandom_range(0, 9) == 0,
                ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom);
      #3;
      checkAll("rand", mActive && !mHolding, mActive && !mHolding && imem_ready && !redirect,
               mActive && mHolding, mPc, mPcOut, mCnt, mDead);
      advance();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
